// File: rtl/ui_uart_pkg.sv
`timescale 1ns/1ps
// Shared UART definitions: transmitter state encoding, parity modes and the
// oversampling ratio of the common baud timing base.
package ui_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;

  localparam int PAR_NONE        = 0;
  localparam int PAR_EVEN        = 1;
  localparam int PAR_ODD         = 2;
  localparam int UART_OVERSAMPLE = 16;

  // Odd parity inverts the XOR so the total count of ones on the line is odd.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    parity_bit = (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/ui_uart_tx_if.sv
`timescale 1ns/1ps
// Byte handshake between the response formatter (master) and the UART
// transmitter (slave).
interface ui_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ui_uart_tx.sv
`timescale 1ns/1ps
// Byte-wide UART transmitter: start bit, 8 data bits LSB first, optional
// parity and 1 or 2 stop bits, timed from a shared 16x baud enable.
module ui_uart_tx
  import ui_uart_pkg::*;
#(
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_x16_en,
  ui_uart_tx_if.slave tx_if,
  output logic       txd,
  output logic       tx_busy
);

  if (!(PARITY == PAR_NONE || PARITY == PAR_EVEN || PARITY == PAR_ODD)) begin : g_bad_parity
    $error("ui_uart_tx: PARITY must be 0, 1 or 2");
  end
  if (!(STOP_BITS == 1 || STOP_BITS == 2)) begin : g_bad_stop
    $error("ui_uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic [3:0] LP_TICK_LAST = 4'(UART_OVERSAMPLE - 1);
  localparam logic       LP_STOP_LAST = 1'(STOP_BITS - 1);

  uart_tx_state_t r_state;
  logic [3:0]     r_tick;
  logic [2:0]     r_bit_idx;
  logic           r_stop_idx;
  logic [7:0]     r_shift;
  logic           r_par;
  logic           r_txd;
  logic           r_ready;
  logic           r_busy;

  uart_tx_state_t w_state_nxt;
  logic [3:0]     w_tick_nxt;
  logic [2:0]     w_bit_idx_nxt;
  logic           w_stop_idx_nxt;
  logic [7:0]     w_shift_nxt;
  logic           w_par_nxt;
  logic           w_txd_nxt;
  logic           w_ready_nxt;
  logic           w_busy_nxt;
  logic           w_tick_en;
  logic           w_bit_end;

  assign w_tick_en = (r_state != ST_IDLE) && baud_x16_en;
  assign w_bit_end = w_tick_en && (r_tick == LP_TICK_LAST);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt    = r_state;
    w_tick_nxt     = w_tick_en ? (r_tick + 4'd1) : r_tick;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_shift_nxt    = r_shift;
    w_par_nxt      = r_par;
    w_txd_nxt      = r_txd;
    w_ready_nxt    = r_ready;
    w_busy_nxt     = r_busy;

    case (r_state)
      ST_IDLE: begin
        if (tx_if.tx_valid && r_ready) begin
          w_state_nxt    = ST_START;
          w_shift_nxt    = tx_if.tx_data;
          w_par_nxt      = parity_bit(tx_if.tx_data, PARITY);
          w_tick_nxt     = 4'd0;
          w_bit_idx_nxt  = 3'd0;
          w_stop_idx_nxt = 1'b0;
          w_txd_nxt      = 1'b0;
          w_ready_nxt    = 1'b0;
          w_busy_nxt     = 1'b1;
        end else begin
          w_txd_nxt = 1'b1;
        end
      end

      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_txd_nxt   = r_shift[0];
        end else begin
          w_txd_nxt = 1'b0;
        end
      end

      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            if (PARITY != PAR_NONE) begin
              w_state_nxt = ST_PARITY;
              w_txd_nxt   = r_par;
            end else begin
              w_state_nxt    = ST_STOP;
              w_stop_idx_nxt = 1'b0;
              w_txd_nxt      = 1'b1;
            end
          end else begin
            // Shift first so bit 0 of the register is always the bit on the line.
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_txd_nxt     = r_shift[1];
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_txd_nxt = r_shift[0];
        end
      end

      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt    = ST_STOP;
          w_stop_idx_nxt = 1'b0;
          w_txd_nxt      = 1'b1;
        end else begin
          w_txd_nxt = r_par;
        end
      end

      ST_STOP: begin
        if (w_bit_end) begin
          if (r_stop_idx == LP_STOP_LAST) begin
            w_state_nxt = ST_IDLE;
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_stop_idx_nxt = r_stop_idx + 1'b1;
          end
        end else begin
          w_txd_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_tick_nxt  = 4'd0;
        w_txd_nxt   = 1'b1;
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, counters, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tick     <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_stop_idx <= 1'b0;
      r_shift    <= 8'd0;
      r_par      <= 1'b0;
      r_txd      <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick     <= w_tick_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_par      <= w_par_nxt;
      r_txd      <= w_txd_nxt;
      r_ready    <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign txd            = r_txd;
  assign tx_busy        = r_busy;
  assign tx_if.tx_ready = r_ready;

endmodule
